// File: rtl/ysyx_25050147_lsu_axi_if.sv
// Request/response handshake and AXI4-Lite channel bundle for the NPC LSU bus master.
// The master modport is the LSU; the slave modport is the side that drives the request and the memory.
interface ysyx_25050147_lsu_axi_if #(
    parameter int unsigned ADDR_W = 32
);
    logic              req_valid;
    logic              req_ready;
    logic              req_wen;
    logic [ADDR_W-1:0] req_addr;
    logic [31:0]       req_wdata;
    logic [7:0]        req_wmask;

    logic              resp_valid;
    logic              resp_ready;
    logic [31:0]       resp_rdata;
    logic              resp_err;

    logic [ADDR_W-1:0] araddr;
    logic              arvalid;
    logic              arready;

    logic [31:0]       rdata;
    logic [1:0]        rresp;
    logic              rvalid;
    logic              rready;

    logic [ADDR_W-1:0] awaddr;
    logic              awvalid;
    logic              awready;

    logic [31:0]       wdata;
    logic [3:0]        wstrb;
    logic              wvalid;
    logic              wready;

    logic [1:0]        bresp;
    logic              bvalid;
    logic              bready;

    modport master (
        input  req_valid, req_wen, req_addr, req_wdata, req_wmask, resp_ready,
        input  arready, rdata, rresp, rvalid, awready, wready, bresp, bvalid,
        output req_ready, resp_valid, resp_rdata, resp_err,
        output araddr, arvalid, rready, awaddr, awvalid, wdata, wstrb, wvalid, bready
    );

    modport slave (
        output req_valid, req_wen, req_addr, req_wdata, req_wmask, resp_ready,
        output arready, rdata, rresp, rvalid, awready, wready, bresp, bvalid,
        input  req_ready, resp_valid, resp_rdata, resp_err,
        input  araddr, arvalid, rready, awaddr, awvalid, wdata, wstrb, wvalid, bready
    );
endinterface

// File: rtl/ysyx_25050147_lsu_axi.sv
// Single-outstanding AXI4-Lite master for NPC loads/stores; all outputs registered.
// Define YSYX_25050147_LSU_MISALIGN_CHECK_EN to fail stores whose byte mask overflows the word.
module ysyx_25050147_lsu_axi #(
    parameter int unsigned ADDR_W = 32
) (
    input  logic                     clock,
    input  logic                     reset_n,
    ysyx_25050147_lsu_axi_if.master  bus
);
    typedef enum logic [2:0] {
        IDLE,
        RADDR,
        RDATA,
        WREQ,
        WRESP,
        DONE
    } state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [3:0]        wstrb_q, wstrb_d;
    logic              wen_q, wen_d;
    logic              req_ready_q, req_ready_d;
    logic              resp_valid_q, resp_valid_d;
    logic              resp_err_q, resp_err_d;
    logic [31:0]       resp_rdata_q, resp_rdata_d;
    logic              arvalid_q, arvalid_d;
    logic              rready_q, rready_d;
    logic              awvalid_q, awvalid_d;
    logic              wvalid_q, wvalid_d;
    logic              bready_q, bready_d;

    logic accept;
    logic misalign;
    logic aw_done;
    logic w_done;

    assign accept = bus.req_valid && req_ready_q;

`ifdef YSYX_25050147_LSU_MISALIGN_CHECK_EN
    assign misalign = bus.req_wen && (bus.req_wmask[7:4] != 4'h0);
`else
    assign misalign = 1'b0;
`endif

    // A channel counts as done once its valid has dropped or is handshaking this cycle.
    assign aw_done = !awvalid_q || bus.awready;
    assign w_done  = !wvalid_q  || bus.wready;

    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        wstrb_d      = wstrb_q;
        wen_d        = wen_q;
        resp_valid_d = resp_valid_q;
        resp_err_d   = resp_err_q;
        resp_rdata_d = resp_rdata_q;
        arvalid_d    = arvalid_q;
        rready_d     = rready_q;
        awvalid_d    = awvalid_q;
        wvalid_d     = wvalid_q;
        bready_d     = bready_q;

        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    addr_d  = {bus.req_addr[ADDR_W-1:2], 2'b00};
                    wdata_d = bus.req_wdata;
                    wstrb_d = bus.req_wmask[3:0];
                    wen_d   = bus.req_wen;
                    if (misalign) begin
                        state_d      = DONE;
                        resp_valid_d = 1'b1;
                        resp_err_d   = 1'b1;
                        resp_rdata_d = '0;
                    end else if (bus.req_wen) begin
                        state_d   = WREQ;
                        awvalid_d = 1'b1;
                        wvalid_d  = 1'b1;
                    end else begin
                        state_d   = RADDR;
                        arvalid_d = 1'b1;
                    end
                end
            end
            RADDR: begin
                if (bus.arready) begin
                    state_d   = RDATA;
                    arvalid_d = 1'b0;
                    rready_d  = 1'b1;
                end
            end
            WREQ: begin
                if (bus.awready) awvalid_d = 1'b0;
                if (bus.wready)  wvalid_d  = 1'b0;
                if (aw_done && w_done) begin
                    state_d  = WRESP;
                    bready_d = 1'b1;
                end
            end
            RDATA, WRESP: begin
                if (wen_q ? bus.bvalid : bus.rvalid) begin
                    state_d      = DONE;
                    rready_d     = 1'b0;
                    bready_d     = 1'b0;
                    resp_valid_d = 1'b1;
                    resp_rdata_d = wen_q ? '0 : bus.rdata;
                    resp_err_d   = wen_q ? (bus.bresp != 2'b00) : (bus.rresp != 2'b00);
                end
            end
            DONE: begin
                if (bus.resp_ready) begin
                    state_d      = IDLE;
                    resp_valid_d = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase

        req_ready_d = (state_d == IDLE);
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            addr_q       <= '0;
            wdata_q      <= '0;
            wstrb_q      <= '0;
            wen_q        <= 1'b0;
            req_ready_q  <= 1'b1;
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
            resp_rdata_q <= '0;
            arvalid_q    <= 1'b0;
            rready_q     <= 1'b0;
            awvalid_q    <= 1'b0;
            wvalid_q     <= 1'b0;
            bready_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            wstrb_q      <= wstrb_d;
            wen_q        <= wen_d;
            req_ready_q  <= req_ready_d;
            resp_valid_q <= resp_valid_d;
            resp_err_q   <= resp_err_d;
            resp_rdata_q <= resp_rdata_d;
            arvalid_q    <= arvalid_d;
            rready_q     <= rready_d;
            awvalid_q    <= awvalid_d;
            wvalid_q     <= wvalid_d;
            bready_q     <= bready_d;
        end
    end

    assign bus.req_ready  = req_ready_q;
    assign bus.resp_valid = resp_valid_q;
    assign bus.resp_err   = resp_err_q;
    assign bus.resp_rdata = resp_rdata_q;
    assign bus.araddr     = addr_q;
    assign bus.arvalid    = arvalid_q;
    assign bus.rready     = rready_q;
    assign bus.awaddr     = addr_q;
    assign bus.awvalid    = awvalid_q;
    assign bus.wdata      = wdata_q;
    assign bus.wstrb      = wstrb_q;
    assign bus.wvalid     = wvalid_q;
    assign bus.bready     = bready_q;
endmodule
